// File: rtl/ps_lane_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps_lane_scheduler_if : requester/serializer signals of the lane scheduler  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface ps_lane_scheduler_if;
  logic       ENABLE;
  logic       REQ_A;
  logic       REQ_B;
  logic [9:0] D_A;
  logic [9:0] D_B;
  logic       GNT_A;
  logic       GNT_B;
  logic       LOAD;
  logic [9:0] D_OUT;
  logic       VALID;
  logic [3:0] BIT_CNT;
  logic [1:0] STATE;

  modport slave (
    input  ENABLE, REQ_A, REQ_B, D_A, D_B,
    output GNT_A, GNT_B, LOAD, D_OUT, VALID, BIT_CNT, STATE
  );

  modport master (
    output ENABLE, REQ_A, REQ_B, D_A, D_B,
    input  GNT_A, GNT_B, LOAD, D_OUT, VALID, BIT_CNT, STATE
  );
endinterface
`default_nettype wire

// File: rtl/ps_lane_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps_lane_scheduler : frames a 10-bit serializer lane, sends comma sync then |
// | round-robin arbitrates two requesters once per frame.  Rev 1.0             |
// +----------------------------------------------------------------------------+
module ps_lane_scheduler #(
  parameter int         SYNC_WORDS = 4,
  parameter logic [9:0] COMMA      = 10'b0011111010
) (
  input wire                 CLOCK,
  input wire                 RESET_L,
  ps_lane_scheduler_if.slave lane
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam int                c_SC_W       = (SYNC_WORDS < 2) ? 1 : $clog2(SYNC_WORDS + 1);
  localparam logic [c_SC_W-1:0] c_SYNC_WORDS = c_SC_W'(SYNC_WORDS);
  localparam logic [c_SC_W-1:0] c_SYNC_ONE   = c_SC_W'(1);
  localparam logic [3:0]        c_LAST_BIT   = 4'd9;

  state_t            r_state,    w_state_nxt;
  logic [3:0]        r_bit_cnt,  w_bit_cnt_nxt;
  logic [c_SC_W-1:0] r_sync_cnt, w_sync_cnt_nxt;
  logic              r_last_b,   w_last_b_nxt;
  logic              r_load,     w_load_nxt;
  logic              r_valid,    w_valid_nxt;
  logic              r_gnt_a,    w_gnt_a_nxt;
  logic              r_gnt_b,    w_gnt_b_nxt;
  logic [9:0]        r_dout,     w_dout_nxt;

  logic w_frame;
  logic w_pick_a;
  logic w_pick_b;

  assign w_frame  = (r_bit_cnt == c_LAST_BIT);
  // On a tie, A wins only when B was the last one served.
  assign w_pick_a = lane.REQ_A & (~lane.REQ_B | r_last_b);
  assign w_pick_b = lane.REQ_B & ~w_pick_a;

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_sync_cnt_nxt = r_sync_cnt;
    w_last_b_nxt   = r_last_b;
    w_load_nxt     = 1'b0;
    w_gnt_a_nxt    = 1'b0;
    w_gnt_b_nxt    = 1'b0;
    w_dout_nxt     = r_dout;
    w_valid_nxt    = r_valid;

    if (!lane.ENABLE) begin
      w_state_nxt    = ST_IDLE;
      w_bit_cnt_nxt  = 4'd0;
      w_sync_cnt_nxt = '0;
      w_dout_nxt     = 10'd0;
      w_valid_nxt    = 1'b0;
    end else if (r_state == ST_IDLE) begin
      w_state_nxt    = ST_SYNC;
      w_bit_cnt_nxt  = 4'd0;
      w_sync_cnt_nxt = c_SYNC_ONE;
      w_load_nxt     = 1'b1;
      w_dout_nxt     = COMMA;
      w_valid_nxt    = 1'b0;
    end else begin
      w_bit_cnt_nxt = w_frame ? 4'd0 : r_bit_cnt + 4'd1;
      if (w_frame) begin
        w_load_nxt = 1'b1;
        if ((r_state == ST_SYNC) && (r_sync_cnt != c_SYNC_WORDS)) begin
          w_sync_cnt_nxt = r_sync_cnt + c_SYNC_ONE;
          w_dout_nxt     = COMMA;
          w_valid_nxt    = 1'b0;
        end else begin
          // The edge that completes the comma run already carries data.
          w_state_nxt    = ST_ACTIVE;
          w_sync_cnt_nxt = '0;
          w_gnt_a_nxt    = w_pick_a;
          w_gnt_b_nxt    = w_pick_b;
          w_valid_nxt    = w_pick_a | w_pick_b;
          w_dout_nxt     = w_pick_a ? lane.D_A : (w_pick_b ? lane.D_B : COMMA);
          if (w_pick_a | w_pick_b) begin
            w_last_b_nxt = w_pick_b;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 4'd0;
      r_sync_cnt <= '0;
      r_last_b   <= 1'b1;
      r_load     <= 1'b0;
      r_valid    <= 1'b0;
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_dout     <= 10'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_sync_cnt <= w_sync_cnt_nxt;
      r_last_b   <= w_last_b_nxt;
      r_load     <= w_load_nxt;
      r_valid    <= w_valid_nxt;
      r_gnt_a    <= w_gnt_a_nxt;
      r_gnt_b    <= w_gnt_b_nxt;
      r_dout     <= w_dout_nxt;
    end
  end

  assign lane.STATE   = r_state;
  assign lane.BIT_CNT = r_bit_cnt;
  assign lane.LOAD    = r_load;
  assign lane.VALID   = r_valid;
  assign lane.GNT_A   = r_gnt_a;
  assign lane.GNT_B   = r_gnt_b;
  assign lane.D_OUT   = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_ps_lane_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ps_lane_scheduler : self-checking bench for ps_lane_scheduler           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ps_lane_scheduler;

  localparam int         c_SYNC_WORDS = 4;
  localparam logic [9:0] c_COMMA      = 10'b0011111010;
  localparam logic [9:0] c_WA         = 10'h2A5;
  localparam logic [9:0] c_WB         = 10'h155;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ps_lane_scheduler_if bus ();

  ps_lane_scheduler #(
    .SYNC_WORDS (c_SYNC_WORDS),
    .COMMA      (c_COMMA)
  ) dut (
    .CLOCK   (clk),
    .RESET_L (rst_n),
    .lane    (bus)
  );

  always #5 clk = ~clk;

  // Model: outputs follow from elapsed cycles since the enabling edge.
  logic       m_on;
  int         m_t;
  int         m_tn;
  logic       m_ptr_b;
  logic       m_ga, m_gb;
  logic [1:0] e_state;
  logic [3:0] e_bit;
  logic       e_load, e_valid, e_gnt_a, e_gnt_b;
  logic [9:0] e_dout;

  assign m_tn = m_t + 1;
  assign m_ga = bus.REQ_A && (!bus.REQ_B || m_ptr_b);
  assign m_gb = bus.REQ_B && !m_ga;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !bus.ENABLE) begin
      m_on    <= 1'b0;
      m_t     <= 0;
      e_state <= 2'd0;
      e_bit   <= 4'd0;
      e_load  <= 1'b0;
      e_valid <= 1'b0;
      e_gnt_a <= 1'b0;
      e_gnt_b <= 1'b0;
      e_dout  <= 10'd0;
      if (!rst_n) m_ptr_b <= 1'b1;
    end else if (!m_on) begin
      m_on    <= 1'b1;
      m_t     <= 0;
      e_state <= 2'd1;
      e_bit   <= 4'd0;
      e_load  <= 1'b1;
      e_valid <= 1'b0;
      e_dout  <= c_COMMA;
    end else begin
      m_t     <= m_tn;
      e_bit   <= 4'(m_tn % 10);
      e_state <= ((m_tn / 10) >= c_SYNC_WORDS) ? 2'd2 : 2'd1;
      e_load  <= (m_tn % 10 == 0);
      e_gnt_a <= 1'b0;
      e_gnt_b <= 1'b0;
      if (m_tn % 10 == 0) begin
        if ((m_tn / 10) < c_SYNC_WORDS) begin
          e_dout  <= c_COMMA;
          e_valid <= 1'b0;
        end else begin
          e_gnt_a <= m_ga;
          e_gnt_b <= m_gb;
          e_valid <= m_ga || m_gb;
          e_dout  <= m_ga ? bus.D_A : (m_gb ? bus.D_B : c_COMMA);
          if (m_ga || m_gb) m_ptr_b <= m_gb;
        end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({bus.STATE, bus.BIT_CNT, bus.LOAD, bus.VALID, bus.GNT_A, bus.GNT_B, bus.D_OUT} !==
        {e_state, e_bit, e_load, e_valid, e_gnt_a, e_gnt_b, e_dout}) begin
      errors++;
      $display("FAIL model t=%0t actual st=%0d bit=%0d ld=%b v=%b ga=%b gb=%b d=%h required st=%0d bit=%0d ld=%b v=%b ga=%b gb=%b d=%h",
               $time, bus.STATE, bus.BIT_CNT, bus.LOAD, bus.VALID, bus.GNT_A, bus.GNT_B, bus.D_OUT,
               e_state, e_bit, e_load, e_valid, e_gnt_a, e_gnt_b, e_dout);
    end
    checks++;
    if ((bus.GNT_A && bus.GNT_B) || ((bus.GNT_A || bus.GNT_B) && !(bus.LOAD && bus.VALID))) begin
      errors++;
      $display("FAIL grant_rule t=%0t actual ga=%b gb=%b ld=%b v=%b required exclusive grant with LOAD and VALID",
               $time, bus.GNT_A, bus.GNT_B, bus.LOAD, bus.VALID);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [1:0] st, input logic [9:0] d,
                           input logic v, input logic ga, input logic gb);
    chk({tag, ".load"},  16'(bus.LOAD),    16'd1);
    chk({tag, ".state"}, 16'(bus.STATE),   16'(st));
    chk({tag, ".bit"},   16'(bus.BIT_CNT), 16'd0);
    chk({tag, ".dout"},  16'(bus.D_OUT),   16'(d));
    chk({tag, ".valid"}, 16'(bus.VALID),   16'(v));
    chk({tag, ".gnt_a"}, 16'(bus.GNT_A),   16'(ga));
    chk({tag, ".gnt_b"}, 16'(bus.GNT_B),   16'(gb));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".state"}, 16'(bus.STATE),   16'd0);
    chk({tag, ".bit"},   16'(bus.BIT_CNT), 16'd0);
    chk({tag, ".load"},  16'(bus.LOAD),    16'd0);
    chk({tag, ".dout"},  16'(bus.D_OUT),   16'd0);
    chk({tag, ".valid"}, 16'(bus.VALID),   16'd0);
    chk({tag, ".gnt"},   16'({bus.GNT_A, bus.GNT_B}), 16'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.ENABLE = 1'b0;
    bus.REQ_A  = 1'b0;
    bus.REQ_B  = 1'b0;
    bus.D_A    = 10'd0;
    bus.D_B    = 10'd0;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("idle");
    bus.ENABLE = 1'b1;

    // Start-up, single requester, tie, no requests, then disable mid-frame.
    for (int c = 0; c <= 105; c++) begin
      @(negedge clk);
      if (c < 40 && c % 10 == 0) chk_frame("sync", 2'd1, c_COMMA, 1'b0, 1'b0, 1'b0);
      if (c == 1) begin
        chk("sync.load_gap", 16'(bus.LOAD), 16'd0);
        chk("sync.bit1", 16'(bus.BIT_CNT), 16'd1);
      end
      if (c == 40 || c == 50) chk_frame("single", 2'd2, c_WA, 1'b1, 1'b1, 1'b0);
      if (c == 41) chk("single.pulse", 16'({bus.LOAD, bus.GNT_A}), 16'd0);
      if (c == 60 || c == 80) chk_frame("tie_b", 2'd2, c_WB, 1'b1, 1'b0, 1'b1);
      if (c == 70) chk_frame("tie_a", 2'd2, c_WA, 1'b1, 1'b1, 1'b0);
      if (c == 90 || c == 100) chk_frame("noreq", 2'd2, c_COMMA, 1'b0, 1'b0, 1'b0);
      if (c == 95) chk("noreq.load_gap", 16'(bus.LOAD), 16'd0);
      if (c == 35) begin bus.REQ_A = 1'b1; bus.D_A = c_WA; end
      if (c == 55) begin bus.REQ_B = 1'b1; bus.D_B = c_WB; end
      if (c == 85) begin bus.REQ_A = 1'b0; bus.REQ_B = 1'b0; end
      if (c == 105) begin
        chk("disable.bit5", 16'(bus.BIT_CNT), 16'd5);
        bus.ENABLE = 1'b0;
        bus.REQ_A  = 1'b1;
      end
    end
    @(negedge clk);
    chk_zero("disabled");
    repeat (3) @(negedge clk);
    bus.ENABLE = 1'b1;

    // Re-enable: full comma run again with REQ_A ignored until ACTIVE.
    for (int d = 0; d <= 45; d++) begin
      @(negedge clk);
      if (d < 40 && d % 10 == 0) chk_frame("resync", 2'd1, c_COMMA, 1'b0, 1'b0, 1'b0);
      if (d == 40) chk_frame("reen", 2'd2, c_WA, 1'b1, 1'b1, 1'b0);
    end

    // Asynchronous reset between edges, mid-frame.
    bus.REQ_B = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    repeat (2) @(negedge clk);
    chk_zero("rst_held");
    rst_n = 1'b1;

    for (int e = 0; e <= 70; e++) begin
      @(negedge clk);
      if (e < 40 && e % 10 == 0) chk_frame("post_rst_sync", 2'd1, c_COMMA, 1'b0, 1'b0, 1'b0);
      if (e == 40 || e == 60) chk_frame("rr_a", 2'd2, c_WA, 1'b1, 1'b1, 1'b0);
      if (e == 50 || e == 70) chk_frame("rr_b", 2'd2, c_WB, 1'b1, 1'b0, 1'b1);
    end

    bus.ENABLE = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("final_idle");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
